// File: rtl/operand_loader.sv
// operand_loader: collects A then B bytes via synchronised strobe edges and offers the pair on op_valid/op_ready, with overrun flag and pair_count
module operand_loader #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 strobe,
  input  logic                 clear,
  input  logic                 op_ready,
  output logic                 op_valid,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] pair_count
);
  typedef enum logic [1:0] {EMPTY, HAVE_A, FULL} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] s_sh;
  logic s_prev, stb_edge, done, load_a, load_b, drop;
  assign stb_edge = s_sh[SYNC_STAGES-1] & ~s_prev;
  assign op_valid = state == FULL;
  always_comb begin
    done = state == FULL && op_ready;
    load_a = !clear && stb_edge && (state == EMPTY || done);
    load_b = !clear && stb_edge && state == HAVE_A;
    drop = !clear && stb_edge && state == FULL && !op_ready;
    state_n = clear ? EMPTY :
              load_a ? HAVE_A :
              load_b ? FULL :
              done ? EMPTY : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      s_sh <= '0;
      s_prev <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      overrun <= 1'b0;
      pair_count <= '0;
    end else begin
      s_sh[0] <= strobe;
      for (int i = 1; i < SYNC_STAGES; i++) s_sh[i] <= s_sh[i-1];
      s_prev <= s_sh[SYNC_STAGES-1];
      state <= state_n;
      if (load_a) op_a <= data_in;
      if (load_b) op_b <= data_in;
      overrun <= clear ? 1'b0 : overrun | drop;
      pair_count <= pair_count + CNT_WIDTH'(done);
    end
  end
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed self-checking bench for operand_loader
module tb_operand_loader;
  logic clk = 0, rst = 0, strobe = 0, clear = 0, op_ready = 0;
  logic [7:0] data_in = 0, op_a, op_b;
  logic op_valid, overrun;
  logic [3:0] pair_count;
  int checks = 0, failures = 0;
  operand_loader dut (
    .clk(clk), .rst(rst), .data_in(data_in), .strobe(strobe), .clear(clear),
    .op_ready(op_ready), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .overrun(overrun), .pair_count(pair_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(posedge clk) #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic load(input logic [7:0] d, input bit rdy = 0, input bit clr = 0, input bit r = 0);
    @(posedge clk) #1 data_in = d;
    strobe = 1;
    @(posedge clk) #1 strobe = 0;
    @(posedge clk) #1 op_ready = rdy;
    clear = clr;
    rst = r;
    @(posedge clk) #1 op_ready = 0;
    clear = 0;
    rst = 0;
  endtask
  task automatic hs();
    @(posedge clk) #1 op_ready = 1;
    @(posedge clk) #1 op_ready = 0;
  endtask
  task automatic pulse_clear();
    @(posedge clk) #1 clear = 1;
    @(posedge clk) #1 clear = 0;
  endtask
  initial begin
    do_reset();
    chk("rst_valid", op_valid, 0);
    chk("rst_a", op_a, 0);
    chk("rst_b", op_b, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_cnt", pair_count, 0);
    load(8'h12);
    chk("basic_a_valid", op_valid, 0);
    chk("basic_a", op_a, 8'h12);
    load(8'h34);
    chk("basic_valid", op_valid, 1);
    chk("basic_pair", {op_a, op_b}, 16'h1234);
    repeat (10) begin
      @(posedge clk) #1;
      chk("basic_stable", {op_valid, op_a, op_b}, {1'b1, 16'h1234});
    end
    hs();
    chk("basic_hs_valid", op_valid, 0);
    chk("basic_hs_cnt", pair_count, 1);
    chk("basic_hs_keep", {op_a, op_b}, 16'h1234);
    do_reset();
    load(8'hAA);
    load(8'h55);
    load(8'hFF);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", op_valid, 1);
    chk("ovr_pair", {op_a, op_b}, 16'hAA55);
    pulse_clear();
    chk("clr_ovr", overrun, 0);
    chk("clr_valid", op_valid, 0);
    chk("clr_cnt", pair_count, 0);
    load(8'h01);
    load(8'h02);
    chk("b2b_full", op_valid, 1);
    load(8'h03, 1);
    chk("b2b_cnt", pair_count, 1);
    chk("b2b_valid", op_valid, 0);
    chk("b2b_a", op_a, 8'h03);
    load(8'h04);
    chk("b2b_valid2", op_valid, 1);
    chk("b2b_pair", {op_a, op_b}, 16'h0304);
    hs();
    chk("hyg_cnt", pair_count, 2);
    @(posedge clk) #1 data_in = 8'h5A;
    strobe = 1;
    repeat (20) @(posedge clk);
    #1 strobe = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_a", op_a, 8'h5A);
    chk("hold_valid", op_valid, 0);
    data_in = 8'h6B;
    @(posedge clk) #8 strobe = 1;
    @(posedge clk) #2 strobe = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("short_valid", op_valid, 1);
    chk("short_pair", {op_a, op_b}, 16'h5A6B);
    do_reset();
    for (int i = 0; i < 15; i++) begin
      load(8'(2 * i));
      load(8'(2 * i + 1));
      hs();
    end
    chk("wrap_cnt15", pair_count, 15);
    load(8'hE0);
    load(8'hE1);
    load(8'h99, 1, 1);
    chk("wrap_cnt0", pair_count, 0);
    chk("wrap_valid", op_valid, 0);
    chk("wrap_noload", op_a, 8'hE0);
    load(8'h77);
    chk("mid_a", op_a, 8'h77);
    chk("mid_valid", op_valid, 0);
    load(8'h88, 0, 0, 1);
    chk("mid_rst_all", {op_valid, op_a, op_b, overrun, pair_count}, 0);
    load(8'h31);
    chk("fresh_a_valid", op_valid, 0);
    load(8'h32);
    chk("fresh_valid", op_valid, 1);
    chk("fresh_pair", {op_a, op_b}, 16'h3132);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
